// File: rtl/mem_arbiter.sv
// Arbiter between NUM_REQ cache requesters and one pipelined fixed-latency main memory.
// Performs full-block read fills (one word address per cycle) and single-word writes.
module mem_arbiter #(
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned WORDS_PER_BLOCK = 8,
   parameter int unsigned ARB_MODE        = 0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ-1:0]                 req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0]          req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]          req_wdata,
   output logic [NUM_REQ-1:0]                 gnt,
   output logic                               resp_valid,
   output logic [DATA_W-1:0]                  resp_data,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] resp_word,
   output logic [NUM_REQ-1:0]                 done,
   output logic [ADDR_W-1:0]                  mem_addr,
   output logic                               mem_enable,
   output logic                               mem_wr,
   output logic [DATA_W-1:0]                  mem_data_in,
   input  logic [DATA_W-1:0]                  mem_data_out,
   input  logic                               mem_data_valid
);
   localparam int unsigned WW  = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned OFF = WW + 1;
   localparam int unsigned PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'((64'd1 << OFF) - 64'd1);
   localparam logic [WW-1:0]     LAST_WORD = WW'(WORDS_PER_BLOCK - 1);
   localparam logic [PW-1:0]     LAST_REQ  = PW'(NUM_REQ - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

   state_t            state;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     win;
   logic [PW-1:0]     cand;
   logic              found;
   int unsigned       idx;
   logic [WW-1:0]     issue_cnt;
   logic [WW-1:0]     rx_cnt;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] sel_addr;
   logic [ADDR_W-1:0] sel_base;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_wr;
   logic              fill_active;
   logic              rx_last;

   // Winner search starts at ptr (round-robin) or at index 0 (fixed priority), then muxes its request.
   always_comb begin
      found     = 1'b0;
      win       = '0;
      idx       = 0;
      cand      = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wr    = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = ((ARB_MODE == 0) ? 32'(ptr) : 32'd0) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = PW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (win == PW'(k)) begin
            sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[k*DATA_W +: DATA_W];
            sel_wr    = req_wr[k];
         end
      end
   end

   assign sel_base    = sel_addr & ~BLK_MASK;
   assign fill_active = (state == ISSUE) || (state == DRAIN);
   assign rx_last     = fill_active && mem_data_valid && (rx_cnt == LAST_WORD);

   // Returned words bypass straight to the requester with no added latency.
   assign resp_valid = fill_active & mem_data_valid;
   assign resp_data  = mem_data_out;
   assign resp_word  = rx_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         gnt         <= '0;
         done        <= '0;
         issue_cnt   <= '0;
         rx_cnt      <= '0;
         base        <= '0;
         mem_addr    <= '0;
         mem_enable  <= 1'b0;
         mem_wr      <= 1'b0;
         mem_data_in <= '0;
      end else begin
         if (fill_active && mem_data_valid) rx_cnt <= rx_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt        <= NUM_REQ'(1) << win;
                  ptr        <= (win == LAST_REQ) ? '0 : win + 1'b1;
                  issue_cnt  <= '0;
                  rx_cnt     <= '0;
                  base       <= sel_base;
                  mem_enable <= 1'b1;
                  if (sel_wr) begin
                     state       <= WRITE;
                     mem_wr      <= 1'b1;
                     mem_addr    <= sel_addr;
                     mem_data_in <= sel_wdata;
                  end else begin
                     state    <= ISSUE;
                     mem_addr <= sel_base;
                  end
               end
            end
            ISSUE: begin
               if (issue_cnt == LAST_WORD) begin
                  mem_enable <= 1'b0;
                  mem_addr   <= '0;
                  // Zero-latency memory can return the final word together with its issue.
                  if (rx_last) begin
                     state <= DONE;
                     done  <= gnt;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  issue_cnt <= issue_cnt + 1'b1;
                  mem_addr  <= base + ADDR_W'({issue_cnt + 1'b1, 1'b0});
               end
            end
            DRAIN: begin
               if (rx_last) begin
                  state <= DONE;
                  done  <= gnt;
               end
            end
            WRITE: begin
               mem_enable  <= 1'b0;
               mem_wr      <= 1'b0;
               mem_addr    <= '0;
               mem_data_in <= '0;
               state       <= DONE;
               done        <= gnt;
            end
            DONE: begin
               done  <= '0;
               gnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a round-robin and a fixed-priority instance
// share one memory model; only the selected instance sees requests.
module tb_mem_arbiter;
   typedef struct packed {
      logic [1:0]  owner;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic        b2b;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        act;
   logic [1:0]  req, req_wr;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req0, req1;
   logic [1:0]  gnt0, gnt1, done0, done1, gnt, done;
   logic        rv0, rv1, resp_valid;
   logic [15:0] rd0, rd1, resp_data;
   logic [2:0]  rw0, rw1, resp_word;
   logic [15:0] ma0, ma1, mem_addr, mdi0, mdi1, mem_data_in;
   logic        me0, me1, mem_enable, mw0, mw1, mem_wr;
   logic [15:0] mem_data_out;
   logic        mem_data_valid;

   always #5 clk = ~clk;

   assign req0 = act ? 2'b00 : req;
   assign req1 = act ? req : 2'b00;
   assign gnt         = act ? gnt1 : gnt0;
   assign done        = act ? done1 : done0;
   assign resp_valid  = act ? rv1 : rv0;
   assign resp_data   = act ? rd1 : rd0;
   assign resp_word   = act ? rw1 : rw0;
   assign mem_addr    = act ? ma1 : ma0;
   assign mem_enable  = act ? me1 : me0;
   assign mem_wr      = act ? mw1 : mw0;
   assign mem_data_in = act ? mdi1 : mdi0;

   mem_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .ARB_MODE(0)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req(req0), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt0), .resp_valid(rv0), .resp_data(rd0), .resp_word(rw0),
      .done(done0), .mem_addr(ma0), .mem_enable(me0), .mem_wr(mw0), .mem_data_in(mdi0),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid));

   mem_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .ARB_MODE(1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req(req1), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt1), .resp_valid(rv1), .resp_data(rd1), .resp_word(rw1),
      .done(done1), .mem_addr(ma1), .mem_enable(me1), .mem_wr(mw1), .mem_data_in(mdi1),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid));

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'd3) ^ 16'h5A5A;
   endfunction

   // Memory model: fixed latency lat (0 = same cycle); writes raise a stray valid for two cycles.
   int          lat;
   logic        mem_clr;
   logic        vpipe [8];
   logic [15:0] dpipe [8];
   logic        stray_q;
   logic        mv;
   logic [15:0] md;

   always @(posedge clk) begin
      for (int i = 7; i > 0; i--) begin
         vpipe[i] <= mem_clr ? 1'b0 : vpipe[i-1];
         dpipe[i] <= dpipe[i-1];
      end
      vpipe[0] <= mem_clr ? 1'b0 : (mem_enable & ~mem_wr);
      dpipe[0] <= mem_word(mem_addr);
      stray_q  <= mem_clr ? 1'b0 : (mem_enable & mem_wr);
   end

   always_comb begin
      mv = 1'b0;
      md = 16'h0;
      if (lat == 0) begin
         mv = mem_enable & ~mem_wr;
         md = mem_word(mem_addr);
      end else begin
         mv = vpipe[lat-1];
         md = dpipe[lat-1];
      end
      mem_data_valid = mv | (mem_enable & mem_wr) | stray_q;
      mem_data_out   = md;
   end

   int   total = 0;
   int   bad   = 0;
   txn_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
      end
   endtask

   // Monitor: pops the expected transaction at each grant and checks it through to done.
   int          cyc = 0, n_iss = 0, n_rx = 0, last_vcyc = 0, done_cyc = 0, grant_cyc = 0;
   logic        busy = 1'b0, bubble = 1'b0;
   logic [1:0]  prev_gnt = 2'b00;
   txn_t        cur;
   logic [15:0] cbase;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n !== 1'b1) begin
            busy = 1'b0; bubble = 1'b0; prev_gnt = 2'b00;
         end else begin
            if (bubble) begin
               chk("bubble_gnt_low", 32'(gnt), 32'd0);
               bubble = 1'b0;
            end
            if (prev_gnt == 2'b00 && gnt != 2'b00) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", 32'(gnt), 32'd0);
               end else begin
                  cur = exp_q.pop_front();
                  busy = 1'b1; n_iss = 0; n_rx = 0; grant_cyc = cyc;
                  cbase = cur.addr & 16'hFFF0;
                  chk("grant_owner", 32'(gnt), 32'd1 << cur.owner);
                  if (cur.b2b) chk("grant_gap", 32'(cyc - done_cyc), 32'd2);
                  if (cur.wr) begin
                     chk("wr_strobe", 32'({mem_enable, mem_wr}), 32'd3);
                     chk("wr_addr", 32'(mem_addr), 32'(cur.addr));
                     chk("wr_data", 32'(mem_data_in), 32'(cur.data));
                  end
               end
            end else if (busy && cur.wr) begin
               chk("wr_single_enable", 32'(mem_enable), 32'd0);
            end
            if (gnt != 2'b00) chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
            if (busy && !cur.wr) begin
               if (mem_enable) begin
                  chk("rd_addr", 32'(mem_addr), 32'(cbase + 16'(2 * n_iss)));
                  chk("rd_no_wr", 32'(mem_wr), 32'd0);
                  n_iss++;
               end else if (n_iss > 0 && n_iss < 8) begin
                  chk("issue_contiguous", 32'(mem_enable), 32'd1);
               end
               if (resp_valid) begin
                  chk("resp_word", 32'(resp_word), 32'(n_rx % 8));
                  chk("resp_data", 32'(resp_data), 32'(mem_word(cbase + 16'(2 * n_rx))));
                  n_rx++;
                  last_vcyc = cyc;
               end
            end else begin
               chk("no_stray_resp", 32'(resp_valid), 32'd0);
            end
            if (done != 2'b00) begin
               if (!busy) begin
                  chk("done_unexpected", 32'(done), 32'd0);
               end else begin
                  chk("done_owner", 32'(done), 32'd1 << cur.owner);
                  chk("done_wdata_zero", 32'(mem_data_in), 32'd0);
                  if (cur.wr) begin
                     chk("wr_done_delay", 32'(cyc - grant_cyc), 32'd1);
                  end else begin
                     chk("done_words", 32'(n_rx), 32'd8);
                     chk("done_issued", 32'(n_iss), 32'd8);
                     chk("done_after_last", 32'(cyc - last_vcyc), 32'd1);
                  end
                  busy = 1'b0; done_cyc = cyc; bubble = 1'b1;
               end
            end
            prev_gnt = gnt;
         end
      end
   end

   // Per-requester transaction lists for one batch, and the model round-robin pointer.
   logic        tx_wr   [2][4];
   logic [15:0] tx_addr [2][4];
   logic [15:0] tx_data [2][4];
   int          ptr_m = 0;

   task automatic load(input int r, input int k);
      req_wr[r]             = tx_wr[r][k];
      req_addr[r*16 +: 16]  = tx_addr[r][k];
      req_wdata[r*16 +: 16] = tx_data[r][k];
   endtask

   // Every requester keeps req high until all its transactions are done; the grant order
   // is predicted from the pending counts alone.
   task automatic run_batch(input int c0, input int c1);
      int   cnt[2], rem[2], nxt[2];
      int   w, start, i, budget;
      logic first;
      txn_t t;
      cnt[0] = c0; cnt[1] = c1; rem[0] = c0; rem[1] = c1;
      first = 1'b1;
      while (rem[0] + rem[1] > 0) begin
         start = act ? 0 : ptr_m;
         w = -1;
         for (int k = 0; k < 2; k++) begin
            i = (start + k) % 2;
            if (w < 0 && rem[i] > 0) w = i;
         end
         t.owner = 2'(w);
         t.wr    = tx_wr[w][cnt[w] - rem[w]];
         t.addr  = tx_addr[w][cnt[w] - rem[w]];
         t.data  = tx_data[w][cnt[w] - rem[w]];
         t.b2b   = !first;
         first   = 1'b0;
         exp_q.push_back(t);
         rem[w]--;
         if (!act) ptr_m = (w + 1) % 2;
      end
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         nxt[r] = 0;
         if (cnt[r] > 0) load(r, 0);
      end
      req = {cnt[1] > 0, cnt[0] > 0};
      budget = 60 * (c0 + c1) + 20;
      while (req != 2'b00 && budget > 0) begin
         @(negedge clk);
         budget--;
         for (int r = 0; r < 2; r++) begin
            if (done[r]) begin
               nxt[r]++;
               if (nxt[r] < cnt[r]) load(r, nxt[r]);
               else req[r] = 1'b0;
            end
         end
      end
      if (budget == 0) begin
         chk("batch_timeout", 32'(req), 32'd0);
         req = 2'b00;
      end
      repeat (4) @(negedge clk);
      chk("batch_all_granted", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic rand_batch();
      int c0, c1;
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      if (c0 + c1 == 0) c0 = 1;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            tx_wr[r][k]   = ($urandom_range(0, 3) == 0);
            tx_addr[r][k] = 16'($urandom);
            if (tx_wr[r][k]) tx_addr[r][k][0] = 1'b0;
            tx_data[r][k] = 16'($urandom);
         end
      end
      run_batch(c0, c1);
   endtask

   task automatic set_read(input int r, input int k, input logic [15:0] a);
      tx_wr[r][k] = 1'b0; tx_addr[r][k] = a; tx_data[r][k] = 16'h0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      txn_t t;
      rst_n = 1'b0; mem_clr = 1'b1; act = 1'b0; lat = 4;
      req = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt0 | gnt1), 32'd0);
      chk("rst_done", 32'(done0 | done1), 32'd0);
      chk("rst_enable", 32'({me0, me1, mw0, mw1}), 32'd0);
      chk("rst_addr", 32'(ma0 | ma1), 32'd0);
      chk("rst_wdata", 32'(mdi0 | mdi1), 32'd0);
      chk("rst_resp_valid", 32'({rv0, rv1}), 32'd0);
      rst_n = 1'b1; mem_clr = 1'b0;
      repeat (2) @(negedge clk);

      // Block fill of 0x0034 at latency 4, then a single write with stray valids.
      set_read(0, 0, 16'h0034);
      run_batch(1, 0);
      tx_wr[1][0] = 1'b1; tx_addr[1][0] = 16'h1002; tx_data[1][0] = 16'hBEEF;
      run_batch(0, 1);

      for (int n = 0; n < 8; n++) begin
         lat = $urandom_range(1, 6);
         rand_batch();
      end

      // Asynchronous reset in the middle of a fill.
      lat = 6;
      @(negedge clk);
      t.owner = 2'd0; t.wr = 1'b0; t.addr = 16'h2468; t.data = 16'h0; t.b2b = 1'b0;
      exp_q.push_back(t);
      set_read(0, 0, 16'h2468);
      load(0, 0);
      req = 2'b01;
      for (int i = 0; i < 60 && n_rx < 3; i++) @(posedge clk);
      chk("prefill_words", 32'(n_rx >= 3), 32'd1);
      #3;
      rst_n = 1'b0;
      req = 2'b00;
      #1;
      chk("async_rst_gnt", 32'(gnt), 32'd0);
      chk("async_rst_enable", 32'({mem_enable, mem_wr}), 32'd0);
      chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      exp_q.delete();
      ptr_m = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      // Both requesters hold two reads each after reset.
      lat = 3;
      for (int k = 0; k < 2; k++) begin
         set_read(0, k, 16'(16'h4000 + 16'(k * 16'h40)));
         set_read(1, k, 16'(16'h8010 + 16'(k * 16'h40)));
      end
      run_batch(2, 2);

      // Zero latency: last word returns together with its issue.
      lat = 0;
      set_read(0, 0, 16'h7FFE);
      run_batch(1, 0);
      for (int n = 0; n < 3; n++) rand_batch();

      // Fixed-priority instance.
      act = 1'b1;
      lat = 2;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) set_read(0, k, 16'(16'h0100 + 16'(k * 16'h10)));
      set_read(1, 0, 16'h0A0A);
      run_batch(3, 1);
      for (int n = 0; n < 5; n++) begin
         lat = $urandom_range(0, 5);
         rand_batch();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised arbiter between N cache requesters and one shared pipelined multicycle main memory (memory4c-style: fixed latency, data_valid per word). It replaces the fixed "ICACHE-first" address/enable muxing. For reads it performs full-block fills, issuing one word address per cycle and steering returned words to the granted requester with a word index. It also performs single-word writes and supports round-robin or fixed-priority arbitration.

Parameters:
NUM_REQ, 2, number of requesters (index 0 = highest fixed priority; I-cache by convention)
ADDR_W, 16, byte address width
DATA_W, 16, word width (a word is 2 bytes)
WORDS_PER_BLOCK, 8, words per cache block, power of 2, >=2
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, held high until done for that requester
req_wr  in  NUM_REQ  1 = single-word write, 0 = block read
req_addr  in  NUM_REQ*ADDR_W  packed byte addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
gnt  out  NUM_REQ  one-hot grant, high for the whole transaction
resp_valid  out  1  returned read word valid this cycle
resp_data  out  DATA_W  returned read word
resp_word  out  log2(WORDS_PER_BLOCK)  index of the returned word within the block
done  out  NUM_REQ  one-cycle pulse to the owner when its transaction completes
mem_addr  out  ADDR_W  memory byte address
mem_enable  out  1  memory request strobe
mem_wr  out  1  memory write strobe (only with mem_enable)
mem_data_in  out  DATA_W  memory write data
mem_data_out  in  DATA_W  memory read data
mem_data_valid  in  1  memory read data valid

Behaviour:
- OFF = log2(WORDS_PER_BLOCK)+1. Block base is captured at grant as {addr[ADDR_W-1:OFF], OFF'b0}. The full address is captured for writes.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - If any req is high, select a winner and register gnt, base address, wr and wdata.
  - Go to WRITE if wr, else ISSUE. gnt rises in the cycle after the request is sampled.
- Round-robin: the search starts at ptr, wrapping modulo NUM_REQ. ptr <= winner+1 (mod NUM_REQ) at grant. ptr resets to 0.
- Fixed priority: the lowest-index asserted req wins; ptr is ignored.
- ISSUE:
  - mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - issue_cnt increments each cycle.
  - After word WORDS_PER_BLOCK-1 is issued, go to DRAIN, or straight to DONE if the final word returns in that same cycle.
- rx_cnt increments on every mem_data_valid while state is ISSUE or DRAIN.
- resp_valid = mem_data_valid & (state is ISSUE or DRAIN); resp_data = mem_data_out; resp_word = rx_cnt. This path is combinational (zero added latency).
- DRAIN: mem_enable=0. When the valid with rx_cnt = WORDS_PER_BLOCK-1 arrives, go to DONE.
- WRITE (one cycle): mem_enable=1, mem_wr=1, mem_addr = captured address, mem_data_in = captured wdata. Next state is DONE.
- DONE (one cycle):
  - done[owner]=1, then gnt=0 and return to IDLE.
  - A new grant can be made in the cycle after DONE, giving one idle bubble between transactions.
- mem_data_valid while IDLE, WRITE or DONE is ignored: resp_valid=0 and counters are unchanged.
- A requester that drops req mid-transaction does not abort it; the transaction completes and done still pulses.
- Simultaneous requests are never merged; exactly one gnt bit is high at any time.
- Reset values (asynchronous, immediate, including mid-fill):
  - State IDLE; all counters and ptr 0.
  - gnt=0, done=0, mem_enable=0, mem_wr=0.
  - mem_addr=0, mem_data_in=0, resp_valid=0.
- mem_data_in is 0 outside WRITE.

Test Plan:
1. RR mode, req[0] read, addr 0x0034, memory latency 4:
   - mem_addr 0x0030, 0x0032 .. 0x003E on 8 consecutive enable cycles.
   - resp_word 0..7 with the matching data.
   - done[0] pulses once, 1 cycle after the word-7 valid; gnt returns to 0.
2. RR mode, req = 2'b11 held, both reads:
   - Grant order is 0, 1, 0, 1 across four transactions.
   - gnt stays one-hot, and there is exactly one idle cycle between each DONE and the next grant.
3. ARB_MODE=1, req = 2'b11 held:
   - req[0] wins every time.
   - After req[0] drops, req[1] is granted on the next grant opportunity.
4. req[1] write, addr 0x1002, wdata 0xBEEF:
   - Exactly one cycle with mem_enable=1, mem_wr=1, mem_addr 0x1002, mem_data_in 0xBEEF.
   - done[1] is pulsed the following cycle.
   - No resp_valid even if a stray mem_data_valid arrives.
5. Reset mid-fill: rst_n low after 3 words received.
   - gnt, mem_enable, resp_valid and done go to 0 asynchronously.
   - Late mem_data_valid pulses are ignored.
   - A new request after reset starts at word 0 and is granted to requester 0 first in RR mode.
6. Final-word edge: memory latency 0 so the last valid coincides with the last issue.
   - FSM goes ISSUE to DONE without entering DRAIN.
   - rx_cnt reaches 7 and done pulses once.
